lane_traffic: RTL and testbench

LANE_TRAFFIC -- requirements
Module: lane_traffic

---
 rtl/lane_traffic.sv | 198 +++++++++++++++++++
 tb/tb_lane_traffic.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lane_traffic.sv
// lane_traffic: multi-lane scrolling traffic generator for a crossing game.
//
// Each lane carries one car that steps one pixel at a lane-specific rate.
// Even lanes drift right and odd lanes drift left, and both wrap at the
// screen edge. A four-state controller (IDLE / RUN / PAUSE / FREEZE) gates
// the motion. A hit freezes the play field for FREEZE_CYCLES clocks and then
// restores the initial layout.
//
// Ports
//   i_Clk    : system clock
//   i_Rst_L  : synchronous active-low reset
//   i_Start  : level request to leave IDLE
//   i_Pause  : level, holds all lanes while high
//   i_Hit    : one-cycle collision pulse
//   i_Level  : difficulty, each step halves the base period
//   o_Car_X  : lane i position at [i*X_WIDTH +: X_WIDTH] (registered)
//   o_Step   : bit i high for the cycle in which lane i moved (registered)
//   o_State  : IDLE=0, RUN=1, PAUSE=2, FREEZE=3
module lane_traffic #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned X_WIDTH       = 10,
    parameter int unsigned SCREEN_W      = 640,
    parameter int unsigned BASE_DIV      = 250000,
    parameter int unsigned LANE_DIV_STEP = 50000,
    parameter int unsigned INIT_STEP     = 160,
    parameter int unsigned FREEZE_CYCLES = 25000000
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_Start,
    input  logic                         i_Pause,
    input  logic                         i_Hit,
    input  logic [2:0]                   i_Level,
    output logic [NUM_LANES*X_WIDTH-1:0] o_Car_X,
    output logic [NUM_LANES-1:0]         o_Step,
    output logic [1:0]                   o_State
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    localparam logic [X_WIDTH-1:0] X_MAX  = X_WIDTH'(SCREEN_W - 1);
    localparam logic [X_WIDTH-1:0] X_ZERO = {X_WIDTH{1'b0}};
    localparam logic [X_WIDTH-1:0] X_ONE  = {{(X_WIDTH-1){1'b0}}, 1'b1};

    state_t                              state_q, state_d;
    logic [24:0]                         frz_cnt_q, frz_cnt_d;
    logic [19:0]                         cnt_q [NUM_LANES];
    logic [19:0]                         cnt_d [NUM_LANES];
    logic [NUM_LANES-1:0][X_WIDTH-1:0]   x_q, x_d;
    logic [NUM_LANES-1:0]                step_q, step_d;
    logic                                run_s;
    logic                                reload_s;
    logic                                frz_done_s;

    // Starting layout: lanes evenly staggered across the screen.
    function automatic logic [X_WIDTH-1:0] init_x_f(input int unsigned lane);
        init_x_f = X_WIDTH'((lane * INIT_STEP) % SCREEN_W);
    endfunction

    // Step period for a lane at a given level, never below one clock.
    function automatic logic [31:0] period_f(input int unsigned lane, input logic [2:0] lvl);
        logic [31:0] p;
        p = (32'(BASE_DIV) >> lvl) + (32'(lane) * 32'(LANE_DIV_STEP));
        if (p == 32'd0) begin
            period_f = 32'd1;
        end else begin
            period_f = p;
        end
    endfunction

    // One-pixel move with wrap so an out-of-range value is never stored.
    function automatic logic [X_WIDTH-1:0] next_x_f(input logic [X_WIDTH-1:0] x, input logic left);
        if (left) begin
            if (x == X_ZERO) begin
                next_x_f = X_MAX;
            end else begin
                next_x_f = x - X_ONE;
            end
        end else begin
            if (x >= X_MAX) begin
                next_x_f = X_ZERO;
            end else begin
                next_x_f = x + X_ONE;
            end
        end
    endfunction

    // Freeze ends on the cycle its counter reaches the last hold clock.
    assign frz_done_s = (state_q == ST_FREEZE) &&
                        (({7'd0, frz_cnt_q} + 32'd1) >= 32'(FREEZE_CYCLES));

    // State register plus all datapath flops; reset wins over everything.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            frz_cnt_q <= 25'd0;
            step_q    <= {NUM_LANES{1'b0}};
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= 20'd0;
                x_q[i]   <= init_x_f(i);
            end
        end else begin
            state_q   <= state_d;
            frz_cnt_q <= frz_cnt_d;
            step_q    <= step_d;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
                x_q[i]   <= x_d[i];
            end
        end
    end

    // Next-state logic; a hit outranks pause in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) state_d = ST_RUN;
                else         state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (i_Hit)        state_d = ST_FREEZE;
                else if (i_Pause) state_d = ST_PAUSE;
                else              state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (i_Hit)         state_d = ST_FREEZE;
                else if (!i_Pause) state_d = ST_RUN;
                else               state_d = ST_PAUSE;
            end
            ST_FREEZE: begin
                if (frz_done_s) state_d = ST_IDLE;
                else            state_d = ST_FREEZE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded controls for the lane datapath.
    always_comb begin
        run_s    = 1'b0;
        reload_s = 1'b0;
        case (state_q)
            ST_RUN:    run_s    = 1'b1;
            ST_FREEZE: reload_s = frz_done_s;
            ST_IDLE:   run_s    = 1'b0;
            ST_PAUSE:  run_s    = 1'b0;
            default: begin
                run_s    = 1'b0;
                reload_s = 1'b0;
            end
        endcase
    end

    // Freeze hold counter; zero whenever not freezing so each freeze starts clean.
    always_comb begin
        if ((state_q == ST_FREEZE) && !frz_done_s) begin
            frz_cnt_d = frz_cnt_q + 25'd1;
        end else begin
            frz_cnt_d = 25'd0;
        end
    end

    // Per-lane rate counters and positions. The >= test lets a shorter
    // period (level raised mid-count) fire at once instead of overflowing.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cnt_d[i]  = cnt_q[i];
            x_d[i]    = x_q[i];
            step_d[i] = 1'b0;
            if (reload_s) begin
                cnt_d[i] = 20'd0;
                x_d[i]   = init_x_f(i);
            end else if (run_s) begin
                if ({12'd0, cnt_q[i]} >= (period_f(i, i_Level) - 32'd1)) begin
                    cnt_d[i]  = 20'd0;
                    x_d[i]    = next_x_f(x_q[i], i[0]);
                    step_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
                x_d[i]   = x_q[i];
            end
        end
    end

    assign o_Car_X = x_q;
    assign o_Step  = step_q;
    assign o_State = state_q;

endmodule

// File: tb/tb_lane_traffic.sv
module tb_lane_traffic;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start;
    logic        pause;
    logic        hit;
    logic [2:0]  level;
    logic [19:0] car_x;
    logic [1:0]  step;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    lane_traffic #(
        .NUM_LANES    (2),
        .X_WIDTH      (10),
        .SCREEN_W     (16),
        .BASE_DIV     (4),
        .LANE_DIV_STEP(2),
        .INIT_STEP    (5),
        .FREEZE_CYCLES(3)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_l),
        .i_Start(start),
        .i_Pause(pause),
        .i_Hit  (hit),
        .i_Level(level),
        .o_Car_X(car_x),
        .o_Step (step),
        .o_State(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int x0, input int x1, input int stp);
        chk({tag, ".state"}, {30'd0, state}, st);
        chk({tag, ".x0"}, {22'd0, car_x[9:0]}, x0);
        chk({tag, ".x1"}, {22'd0, car_x[19:10]}, x1);
        chk({tag, ".step"}, {30'd0, step}, stp);
    endtask

    initial begin
        rst_l = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        hit   = 1'b0;
        level = 3'd0;
        @(negedge clk);

        // Reset held for two edges
        tick();
        tick();
        chk_all("reset", 0, 0, 5, 0);

        // Hit is ignored in IDLE
        rst_l = 1'b1;
        hit   = 1'b1;
        tick();
        hit = 1'b0;
        chk_all("idle_hit", 0, 0, 5, 0);

        // Start at level 0: lane0 every 4 clocks right, lane1 every 6 left
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.state", {30'd0, state}, 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_all("lvl0", 1, k / 4, 5 - k / 6,
                    ((k % 6 == 0) ? 2 : 0) + ((k % 4 == 0) ? 1 : 0));
        end

        // Two more counts, then raise level mid-count: both lanes fire at once
        tick();
        tick();
        chk_all("precount", 1, 3, 3, 0);
        level = 3'd2;
        tick();
        chk_all("lvl_raise", 1, 4, 2, 3);

        // Level 2: lane0 every clock, lane1 every 3; covers both wraps
        for (int m = 1; m <= 12; m++) begin
            tick();
            chk_all("lvl2", 1, (4 + m) % 16, (18 - m / 3) % 16,
                    ((m % 3 == 0) ? 2 : 0) + 1);
        end
        chk("wrap.x0_to_0", {22'd0, car_x[9:0]}, 0);
        chk("wrap.x1_past_15", {22'd0, car_x[19:10]}, 14);

        // Back to level 0, build counts of 2 before pausing
        level = 3'd0;
        tick();
        tick();
        chk_all("prepause", 1, 0, 14, 0);

        // Pause 10 cycles: first edge still counts (to 3), then all held
        pause = 1'b1;
        for (int p = 0; p < 10; p++) begin
            tick();
            chk_all("pause", 2, 0, 14, 0);
        end

        // Release: one edge to re-enter RUN, then held count 3 fires lane0
        pause = 1'b0;
        tick();
        chk_all("resume0", 1, 0, 14, 0);
        tick();
        chk_all("resume1", 1, 1, 14, 1);
        tick();
        chk_all("resume2", 1, 1, 14, 0);
        tick();
        chk_all("resume3", 1, 1, 13, 2);

        // Hit with pause in same cycle: hit wins, freeze 3 cycles
        hit   = 1'b1;
        pause = 1'b1;
        tick();
        hit   = 1'b0;
        pause = 1'b0;
        chk_all("freeze0", 3, 1, 13, 0);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk_all("freeze1", 3, 1, 13, 0);
        tick();
        chk_all("freeze2", 3, 1, 13, 0);
        tick();
        chk_all("unfreeze", 0, 0, 5, 0);

        // Counters were cleared: first lane0 step 4 clocks after RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.state", {30'd0, state}, 1);
        tick();
        tick();
        tick();
        chk_all("restart3", 1, 0, 5, 0);
        tick();
        chk_all("restart4", 1, 1, 5, 1);

        // Reset in the middle of FREEZE
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("freeze_b.state", {30'd0, state}, 3);
        rst_l = 1'b0;
        tick();
        chk_all("rst_in_freeze", 0, 0, 5, 0);
        rst_l = 1'b1;
        tick();
        chk_all("post_rst", 0, 0, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
